md_unit_sched: RTL

//  E-stage multiply/divide unit with its own sequencer. It owns HI/LO, times multi-cycle mult/div, and handles mthi/mtlo/mfhi/mflo.
//  It raises a D-stage stall whenever the decoder's MDen flags an MD-class instruction while the unit is busy.
//  It sits beside the E-stage ALU and feeds the E->M result mux through rdata.

---
 rtl/md_unit_sched_pkg.sv | 29 ++
 rtl/md_unit_sched_md_calc.sv | 76 +++++++
 rtl/md_unit_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/md_unit_sched_pkg.sv
// Shared MD-unit definitions: op codes for the E-stage MD instruction and sequencer states.
package md_unit_sched_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    typedef enum logic {
        MDS_IDLE,
        MDS_BUSY
    } md_state_t;

    function automatic logic is_mult_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_sched_md_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu; division by zero holds HI/LO.
module md_calc
    import md_unit_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    md_op_t      op_e;
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] sdiv_b;
    logic [31:0] udiv_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign op_e = md_op_t'(op);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substituting divisor 1 for the overflow case yields quot=0x80000000, rem=0 directly.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sdiv_b  = ((b == '0) || div_ovf) ? 32'd1 : b;
    assign udiv_b  = (b == '0) ? 32'd1 : b;

    assign quot_s = $signed(a) / $signed(sdiv_b);
    assign rem_s  = $signed(a) % $signed(sdiv_b);
    assign quot_u = a / udiv_b;
    assign rem_u  = a % udiv_b;

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        case (op_e)
            MD_MULT: begin
                hi_n = prod_s[63:32];
                lo_n = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_n = prod_u[63:32];
                lo_n = prod_u[31:0];
            end
            MD_DIV: begin
                if (b != '0) begin
                    hi_n = rem_s;
                    lo_n = quot_s;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    hi_n = rem_u;
                    lo_n = quot_u;
                end
            end
            default: begin
                hi_n = hi;
                lo_n = lo;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_sched.sv
// E-stage multiply/divide unit: owns HI/LO, sequences multi-cycle mult/div, serves mt/mf ops
// and raises the D-stage stall when an MD instruction is decoded while the unit is occupied.
module md_unit_sched
    import md_unit_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic        e_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_mden,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    md_op_t           op;
    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_pend;
    logic [31:0]      lo_pend;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             start;

    assign op = md_op_t'(e_op);

    md_calc u_md_calc (
        .op   (e_op),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .hi_n (calc_hi),
        .lo_n (calc_lo)
    );

    assign start = !reset && e_valid && (is_mult_op(op) || is_div_op(op)) && (state == MDS_IDLE);
    assign busy  = start || (state == MDS_BUSY);
    assign stall = d_mden && busy;

    always_comb begin
        rdata = '0;
        if (e_valid) begin
            if (op == MD_MFHI) begin
                rdata = hi;
            end else if (op == MD_MFLO) begin
                rdata = lo;
            end
        end
    end

    // Results are captured at start and committed only on the final busy edge,
    // so a reset mid-sequence discards them without touching HI/LO beyond the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MDS_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
        end else begin
            case (state)
                MDS_IDLE: begin
                    if (start) begin
                        hi_pend <= calc_hi;
                        lo_pend <= calc_lo;
                        cnt     <= is_mult_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state   <= MDS_BUSY;
                    end else if (e_valid && (op == MD_MTHI)) begin
                        hi <= a;
                    end else if (e_valid && (op == MD_MTLO)) begin
                        lo <= a;
                    end
                end
                MDS_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= hi_pend;
                        lo    <= lo_pend;
                        state <= MDS_IDLE;
                    end
                end
                default: begin
                    state <= MDS_IDLE;
                end
            endcase
        end
    end

endmodule
